// File: rtl/mul.sv
// mul -- pipelined signed two's-complement multiplier, o_do = i_d1 * i_d2.
//
// Three register stages, one new operand pair accepted every clock:
//   stage 1: capture the operands
//   stage 2: radix-4 Booth recode of the multiplier, partial products of the
//            multiplicand at OW bits, carry-save reduction to sum/carry
//   stage 3: carry-propagate add of sum/carry into the output register
// Operands sampled on rising edge k appear on o_do just after edge k+2.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset, clears every pipeline register
//   i_d1   in   DW-bit multiplicand, signed
//   i_d2   in   DW-bit multiplier, signed
//   o_do   out  OW-bit product, signed, registered
//
// The product output is named o_do because a bare "do" is a reserved
// keyword in SystemVerilog.
module mul #(
    parameter int DW = 9,
    parameter int OW = 18
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] i_d1,
    input  logic [DW-1:0] i_d2,
    output logic [OW-1:0] o_do
);

    // Number of Booth digits; the multiplier is sign-extended to EW = 2*ND
    // bits, which is always at least one bit wider than DW.
    localparam int ND = (DW + 2) / 2;
    localparam int EW = 2 * ND;

    if (DW < 2) begin : g_bad_dw
        $error("mul: DW must be at least 2");
    end
    if (OW != 2 * DW) begin : g_bad_ow
        $error("mul: OW must equal 2*DW");
    end

    // ------------------------------------------------------------------
    // Stage 1: operand registers
    // ------------------------------------------------------------------
    logic [DW-1:0] r_d1;
    logic [DW-1:0] r_d2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d1 <= '0;
            r_d2 <= '0;
        end else begin
            r_d1 <= i_d1;
            r_d2 <= i_d2;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: Booth recoding, partial products, carry-save reduction
    // ------------------------------------------------------------------
    logic [OW-1:0] w_a;     // multiplicand sign-extended to product width
    logic [EW:0]   w_y;     // sign-extended multiplier with implicit y[-1]=0

    assign w_a = {{(OW - DW){r_d1[DW-1]}}, r_d1};
    assign w_y = {{(EW - DW){r_d2[DW-1]}}, r_d2, 1'b0};

    logic [ND-1:0][OW-1:0] w_pp;    // weighted partial products
    logic [ND-1:0][OW-1:0] w_s;     // running carry-save sum
    logic [ND-1:0][OW-1:0] w_c;     // running carry-save carry

    for (genvar gi = 0; gi < ND; gi++) begin : g_booth
        logic [2:0]    w_bits;
        logic [OW-1:0] w_mag;

        // Bits y[2i+1], y[2i], y[2i-1] select digit -2y[2i+1]+y[2i]+y[2i-1].
        assign w_bits = w_y[2*gi+2 -: 3];

        always_comb begin
            w_mag = '0;
            case (w_bits)
                3'b001, 3'b010: w_mag = w_a;
                3'b011:         w_mag = w_a << 1;
                3'b100:         w_mag = -(w_a << 1);
                3'b101, 3'b110: w_mag = -w_a;
                default:        w_mag = '0;
            endcase
        end

        // Digit i carries weight 4^i; bits shifted past OW are discarded,
        // which is harmless since all arithmetic is modulo 2^OW.
        assign w_pp[gi] = w_mag << (2 * gi);
    end

    // Chain of 3:2 compressors folds each partial product into sum/carry.
    assign w_s[0] = w_pp[0];
    assign w_c[0] = '0;

    for (genvar gi = 1; gi < ND; gi++) begin : g_csa
        assign w_s[gi] = w_s[gi-1] ^ w_c[gi-1] ^ w_pp[gi];
        assign w_c[gi] = ((w_s[gi-1] & w_c[gi-1]) |
                          (w_s[gi-1] & w_pp[gi])  |
                          (w_c[gi-1] & w_pp[gi])) << 1;
    end

    logic [OW-1:0] r_sum;
    logic [OW-1:0] r_carry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum   <= '0;
            r_carry <= '0;
        end else begin
            r_sum   <= w_s[ND-1];
            r_carry <= w_c[ND-1];
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: carry-propagate add
    // ------------------------------------------------------------------
    logic [OW-1:0] r_do;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_do <= '0;
        end else begin
            r_do <= r_sum + r_carry;
        end
    end

    assign o_do = r_do;

endmodule

// File: tb/tb_mul.sv
// tb_mul -- directed self-checking bench for the pipelined multiplier.
// Each step drives an operand pair on the falling edge and, just after the
// next rising edge, checks o_do against the hand-computed product of the
// pair driven two steps earlier.
module tb_mul;

    logic        clk;
    logic        rst_n;
    logic [8:0]  d1;
    logic [8:0]  d2;
    logic [17:0] prod;

    int checks = 0;
    int errors = 0;

    mul #(.DW(9), .OW(18)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d1  (d1),
        .i_d2  (d2),
        .o_do  (prod)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [17:0] exp);
        checks++;
        assert (prod === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, prod, exp);
        end
        $display("check %-12s a=%h b=%h do=%h exp=%h", tag, d1, d2, prod, exp);
    endtask

    task automatic step(input string tag, input logic [8:0] a, input logic [8:0] b,
                        input logic [17:0] exp);
        @(negedge clk);
        d1 = a;
        d2 = b;
        @(posedge clk);
        #1;
        check(tag, exp);
    endtask

    initial begin
        rst_n = 1'b0;
        d1    = '0;
        d2    = '0;

        #3;
        check("reset", 18'h00000);
        #9;                       // release at t=12, between edges
        rst_n = 1'b1;

        step("post_rst0",  9'h002, 9'h006, 18'h00000);
        step("post_rst1",  9'h064, 9'h064, 18'h00000);
        step("2x6",        9'h1F6, 9'h00A, 18'h0000C);
        step("100x100",    9'h19C, 9'h19C, 18'h02710);
        step("-10x10",     9'h100, 9'h100, 18'h3FF9C);
        step("-100x-100",  9'h0FF, 9'h100, 18'h02710);
        step("-256x-256",  9'h001, 9'h1FF, 18'h10000);
        step("255x-256",   9'h100, 9'h0FF, 18'h30100);
        step("1x-1",       9'h007, 9'h1FD, 18'h3FFFF);
        step("-256x255",   9'h000, 9'h000, 18'h30100);
        step("7x-3",       9'h000, 9'h000, 18'h3FFEB);

        // Asynchronous reset between edges with live data in the pipeline.
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst", 18'h00000);

        d1 = 'x;
        d2 = 'x;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_x_in", 18'h00000);

        #2;
        rst_n = 1'b1;
        d1    = '0;
        d2    = '0;
        step("rel_edge0",  9'h003, 9'h003, 18'h00000);
        step("rel_edge1",  9'h000, 9'h000, 18'h00000);
        step("3x3",        9'h000, 9'h000, 18'h00009);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
